// File: rtl/otp_cipher_engine.sv
// otp_cipher_engine: one-time-pad encrypt/decrypt over a MSG_LEN-symbol key buffer; define OTP_KEY_ZEROISE_EN to wipe keys after a decrypt
module otp_cipher_engine #(
  parameter int SYM_W   = 5,
  parameter int ALPHA   = 27,
  parameter int MSG_LEN = 4,
  parameter int IDX_W   = $clog2(MSG_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [SYM_W-1:0] sym_in_i,
  input  logic [SYM_W-1:0] rand_num_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [SYM_W-1:0] sym_out_o,
  output logic [SYM_W-1:0] key_out_o,
  output logic             out_err_o,
  output logic [IDX_W-1:0] sym_idx_o,
  output logic             msg_done_o,
  output logic             keys_held_o
);
  typedef enum logic [1:0] {IDLE, ENC, DEC} state_t;
  localparam logic [SYM_W:0] A1 = (SYM_W+1)'(ALPHA);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(MSG_LEN - 1);
  state_t state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d, sidx_q, sidx_d;
  logic [SYM_W-1:0] key_mem_q [MSG_LEN];
  logic [SYM_W-1:0] key_mem_d [MSG_LEN];
  logic keys_held_q, keys_held_d, valid_q, valid_d, err_q, err_d, done_q, done_d;
  logic [SYM_W-1:0] sym_q, sym_d, key_q, key_d;
  logic acc, illegal, last, enc;
  logic [SYM_W-1:0] k, c_enc, kmem, p_dec;
  logic [SYM_W:0] sum;
  assign in_ready_o  = !valid_q | out_ready_i;
  assign acc         = in_valid_i & in_ready_o;
  assign illegal     = {1'b0, sym_in_i} >= A1;
  assign last        = idx_q == LAST;
  assign enc         = (state_q == IDLE) ? !mode_i : (state_q == ENC);
  assign k           = ({1'b0, rand_num_i} >= A1) ? SYM_W'({1'b0, rand_num_i} - A1) : rand_num_i;
  assign sum         = {1'b0, sym_in_i} + {1'b0, k};
  assign c_enc       = (sum >= A1) ? SYM_W'(sum - A1) : SYM_W'(sum);
  assign kmem        = key_mem_q[idx_q];
  assign p_dec       = (sym_in_i >= kmem) ? sym_in_i - kmem : SYM_W'({1'b0, sym_in_i} + A1 - {1'b0, kmem});
  assign out_valid_o = valid_q;
  assign sym_out_o   = sym_q;
  assign key_out_o   = key_q;
  assign out_err_o   = err_q;
  assign sym_idx_o   = sidx_q;
  assign msg_done_o  = done_q;
  assign keys_held_o = keys_held_q;
  // Next state, key buffer updates and output register loads; a decrypt start without keys is rejected in place
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    keys_held_d = keys_held_q;
    key_mem_d   = key_mem_q;
    valid_d     = valid_q & ~out_ready_i;
    sym_d       = sym_q;
    key_d       = key_q;
    err_d       = err_q;
    sidx_d      = sidx_q;
    done_d      = done_q;
    if (acc) begin
      valid_d = 1'b1;
      sidx_d  = idx_q;
      done_d  = last;
      err_d   = illegal;
      sym_d   = '0;
      key_d   = '0;
      if (!enc && state_q == IDLE && !keys_held_q) begin
        err_d = 1'b1;
      end else begin
        idx_d   = last ? '0 : idx_q + 1'b1;
        state_d = last ? IDLE : (enc ? ENC : DEC);
        if (enc) begin
          if (state_q == IDLE) begin
            keys_held_d = 1'b0;
            key_mem_d   = '{default: '0};
          end
          key_mem_d[idx_q] = illegal ? '0 : k;
          sym_d = illegal ? '0 : c_enc;
          key_d = illegal ? '0 : k;
          if (last) keys_held_d = 1'b1;
        end else begin
          if (illegal) key_mem_d[idx_q] = '0;
          sym_d = illegal ? '0 : p_dec;
          key_d = illegal ? '0 : kmem;
`ifdef OTP_KEY_ZEROISE_EN
          if (last) begin
            key_mem_d   = '{default: '0};
            keys_held_d = 1'b0;
          end
`endif
        end
      end
    end
  end
  // State and output registers; reset abandons the message, wipes keys and drops pending output
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      keys_held_q <= 1'b0;
      key_mem_q   <= '{default: '0};
      valid_q     <= 1'b0;
      sym_q       <= '0;
      key_q       <= '0;
      err_q       <= 1'b0;
      sidx_q      <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      keys_held_q <= keys_held_d;
      key_mem_q   <= key_mem_d;
      valid_q     <= valid_d;
      sym_q       <= sym_d;
      key_q       <= key_d;
      err_q       <= err_d;
      sidx_q      <= sidx_d;
      done_q      <= done_d;
    end
  end
endmodule

// File: tb/tb_otp_cipher_engine.sv
// tb_otp_cipher_engine: scoreboard bench for otp_cipher_engine (ALPHA=27, MSG_LEN=4)
module tb_otp_cipher_engine;
  logic clk = 1'b0, rst = 1'b0, mode_i = 1'b0, in_valid_i = 1'b0, out_ready_i = 1'b1;
  logic [4:0] sym_in_i = '0, rand_num_i = '0;
  logic in_ready_o, out_valid_o, out_err_o, msg_done_o, keys_held_o;
  logic [4:0] sym_out_o, key_out_o;
  logic [1:0] sym_idx_o;
  typedef struct packed {
    logic [4:0] sym;
    logic [4:0] key;
    logic       err;
    logic [1:0] idx;
    logic       done;
  } exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0;
  int m_st = 0, m_idx = 0;
  bit m_held = 0;
  int m_keys[4];

  otp_cipher_engine dut (
    .clk(clk), .rst(rst), .mode_i(mode_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .sym_in_i(sym_in_i), .rand_num_i(rand_num_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .sym_out_o(sym_out_o), .key_out_o(key_out_o), .out_err_o(out_err_o), .sym_idx_o(sym_idx_o),
    .msg_done_o(msg_done_o), .keys_held_o(keys_held_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    exp_t a, e;
    if (rst && out_valid_o && out_ready_i) begin
      a = {sym_out_o, key_out_o, out_err_o, sym_idx_o, msg_done_o};
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected got sym=%0d key=%0d err=%0b idx=%0d done=%0b with nothing expected",
                 a.sym, a.key, a.err, a.idx, a.done);
      end else begin
        e = sb.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL sb_out got sym=%0d key=%0d err=%0b idx=%0d done=%0b exp sym=%0d key=%0d err=%0b idx=%0d done=%0b",
                   a.sym, a.key, a.err, a.idx, a.done, e.sym, e.key, e.err, e.idx, e.done);
        end
      end
    end
  end

  task automatic model_reset();
    m_st = 0;
    m_idx = 0;
    m_held = 0;
    foreach (m_keys[i]) m_keys[i] = 0;
    sb.delete();
  endtask

  task automatic drive(input bit m, input int s, input int r, output exp_t e);
    int n = 0;
    int kk;
    bit enc, ill, lst;
    mode_i = m;
    sym_in_i = 5'(s);
    rand_num_i = 5'(r);
    in_valid_i = 1'b1;
    @(negedge clk);
    while (!in_ready_o && n < 50) begin
      n++;
      @(negedge clk);
    end
    e = '0;
    if (!in_ready_o) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout in_ready=%0b need 1", in_ready_o);
    end else begin
      enc = (m_st == 0) ? !m : (m_st == 1);
      ill = s >= 27;
      lst = m_idx == 3;
      e.idx = 2'(m_idx);
      e.err = ill;
      e.done = lst;
      if (!enc && m_st == 0 && !m_held) begin
        e.err = 1'b1;
        e.done = 1'b0;
      end else begin
        if (enc) begin
          if (m_st == 0) begin
            m_held = 0;
            foreach (m_keys[i]) m_keys[i] = 0;
          end
          kk = (r >= 27) ? r - 27 : r;
          m_keys[m_idx] = ill ? 0 : kk;
          if (!ill) begin
            e.sym = 5'((s + kk) % 27);
            e.key = 5'(kk);
          end
          if (lst) m_held = 1;
          m_st = lst ? 0 : 1;
        end else begin
          kk = m_keys[m_idx];
          if (ill) m_keys[m_idx] = 0;
          else begin
            e.sym = 5'((s + 27 - kk) % 27);
            e.key = 5'(kk);
          end
          m_st = lst ? 0 : 2;
`ifdef OTP_KEY_ZEROISE_EN
          if (lst) begin
            m_held = 0;
            foreach (m_keys[i]) m_keys[i] = 0;
          end
`endif
        end
        m_idx = lst ? 0 : m_idx + 1;
      end
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    in_valid_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({out_valid_o, sym_out_o, key_out_o, out_err_o, sym_idx_o, msg_done_o, keys_held_o} !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs got v=%0b sym=%0d key=%0d err=%0b idx=%0d done=%0b held=%0b need all 0",
               out_valid_o, sym_out_o, key_out_o, out_err_o, sym_idx_o, msg_done_o, keys_held_o);
    end
    checks++;
    if (in_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %0b need 1", in_ready_o);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_encrypt_basic();
    exp_t e;
    drive(0, 20, 10, e);
    checks++;
    if ({out_valid_o, sym_out_o, key_out_o, sym_idx_o} !== {1'b1, 5'd3, 5'd10, 2'd0}) begin
      errors++;
      $display("FAIL enc_first got v=%0b sym=%0d key=%0d idx=%0d need v=1 sym=3 key=10 idx=0",
               out_valid_o, sym_out_o, key_out_o, sym_idx_o);
    end
    drive(0, 1, 30, e);
    checks++;
    if ({sym_out_o, key_out_o} !== {5'd4, 5'd3}) begin
      errors++;
      $display("FAIL enc_key_reduce got sym=%0d key=%0d need sym=4 key=3", sym_out_o, key_out_o);
    end
    drive(0, 26, 26, e);
    checks++;
    if (sym_out_o !== 5'd25) begin
      errors++;
      $display("FAIL enc_wrap got sym=%0d need 25", sym_out_o);
    end
    drive(0, 5, 0, e);
    checks++;
    if ({msg_done_o, keys_held_o} !== 2'b11) begin
      errors++;
      $display("FAIL enc_last got done=%0b held=%0b need done=1 held=1", msg_done_o, keys_held_o);
    end
  endtask

  task automatic test_roundtrip();
    exp_t e;
    int pt[4] = '{7, 0, 26, 13};
    int ct[4];
    for (int i = 0; i < 4; i++) begin
      drive(0, pt[i], int'($urandom_range(0, 31)), e);
      ct[i] = int'(e.sym);
    end
    for (int i = 0; i < 4; i++) begin
      drive(i == 0 ? 1'b1 : 1'b0, ct[i], int'($urandom_range(0, 31)), e);
      checks++;
      if (sym_out_o !== 5'(pt[i]) || out_err_o !== 1'b0) begin
        errors++;
        $display("FAIL dec_restore[%0d] got sym=%0d err=%0b need sym=%0d err=0", i, sym_out_o, out_err_o, pt[i]);
      end
    end
    checks++;
    if (keys_held_o !== m_held) begin
      errors++;
      $display("FAIL dec_keys_held got %0b need %0b", keys_held_o, m_held);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1, ct[i], 0, e);
      checks++;
`ifdef OTP_KEY_ZEROISE_EN
      if (out_err_o !== 1'b1 || sym_out_o !== 5'd0) begin
        errors++;
        $display("FAIL dec_repeat[%0d] got sym=%0d err=%0b need sym=0 err=1", i, sym_out_o, out_err_o);
      end
`else
      if (out_err_o !== 1'b0 || sym_out_o !== 5'(pt[i])) begin
        errors++;
        $display("FAIL dec_repeat[%0d] got sym=%0d err=%0b need sym=%0d err=0", i, sym_out_o, out_err_o, pt[i]);
      end
`endif
    end
  endtask

  task automatic test_backpressure();
    exp_t ea, eb;
    repeat (2) @(posedge clk);
    #1;
    out_ready_i = 1'b0;
    drive(0, 3, 4, ea);
    mode_i = 1'b0;
    sym_in_i = 5'd9;
    rand_num_i = 5'd2;
    in_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready_o !== 1'b0 || out_valid_o !== 1'b1 ||
          {sym_out_o, key_out_o, out_err_o, sym_idx_o, msg_done_o} !== ea) begin
        errors++;
        $display("FAIL stall[%0d] got rdy=%0b v=%0b sym=%0d key=%0d need rdy=0 v=1 sym=%0d key=%0d",
                 i, in_ready_o, out_valid_o, sym_out_o, key_out_o, ea.sym, ea.key);
      end
    end
    @(posedge clk);
    #1;
    out_ready_i = 1'b1;
    drive(0, 9, 2, eb);
    drive(0, 11, 12, eb);
    drive(0, 0, 31, eb);
  endtask

  task automatic test_no_keys();
    exp_t e;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    drive(1, 5, 0, e);
    checks++;
    if ({out_err_o, sym_out_o, keys_held_o} !== {1'b1, 5'd0, 1'b0}) begin
      errors++;
      $display("FAIL dec_no_keys got err=%0b sym=%0d held=%0b need err=1 sym=0 held=0", out_err_o, sym_out_o, keys_held_o);
    end
    drive(1, 29, 0, e);
    checks++;
    if (out_err_o !== 1'b1) begin
      errors++;
      $display("FAIL dec_illegal got err=%0b need 1", out_err_o);
    end
  endtask

  task automatic test_illegal_enc();
    exp_t e;
    int ct[4];
    drive(0, 29, 7, e);
    ct[0] = 10;
    checks++;
    if ({out_err_o, sym_out_o, key_out_o, sym_idx_o} !== {1'b1, 5'd0, 5'd0, 2'd0}) begin
      errors++;
      $display("FAIL enc_illegal got err=%0b sym=%0d key=%0d idx=%0d need err=1 sym=0 key=0 idx=0",
               out_err_o, sym_out_o, key_out_o, sym_idx_o);
    end
    drive(0, 4, 5, e);
    ct[1] = int'(e.sym);
    checks++;
    if (sym_idx_o !== 2'd1) begin
      errors++;
      $display("FAIL enc_idx_advance got %0d need 1", sym_idx_o);
    end
    drive(0, 17, 20, e);
    ct[2] = int'(e.sym);
    drive(0, 8, 28, e);
    ct[3] = int'(e.sym);
    for (int i = 0; i < 4; i++) drive(1, ct[i], 0, e);
  endtask

  task automatic test_reset_mid();
    exp_t e;
    drive(0, 2, 3, e);
    drive(0, 4, 5, e);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({out_valid_o, sym_out_o, key_out_o, out_err_o, sym_idx_o, msg_done_o, keys_held_o} !== 16'h0) begin
      errors++;
      $display("FAIL reset_mid got v=%0b sym=%0d key=%0d err=%0b idx=%0d done=%0b held=%0b need all 0",
               out_valid_o, sym_out_o, key_out_o, out_err_o, sym_idx_o, msg_done_o, keys_held_o);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    drive(0, 6, 7, e);
    checks++;
    if ({sym_idx_o, sym_out_o} !== {2'd0, 5'd13}) begin
      errors++;
      $display("FAIL reset_restart got idx=%0d sym=%0d need idx=0 sym=13", sym_idx_o, sym_out_o);
    end
  endtask

  initial begin
    test_reset();
    test_encrypt_basic();
    test_roundtrip();
    test_backpressure();
    test_no_keys();
    test_illegal_enc();
    test_reset_mid();
    repeat (3) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got %0d pending need 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
